// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input block: color codes, event FSM
// states, default debounce width and small one-hot helpers.
package btn_pkg;

  localparam int DB_CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    COLOR_U = 2'd0,
    COLOR_R = 2'd1,
    COLOR_D = 2'd2,
    COLOR_L = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_READY    = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  // Bit order of the button vector is {U,R,D,L}.
  function automatic color_e color_of(input logic [3:0] onehot);
    color_e c;
    case (onehot)
      4'b0100: c = COLOR_R;
      4'b0010: c = COLOR_D;
      4'b0001: c = COLOR_L;
      default: c = COLOR_U;
    endcase
    return c;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a stability counter; the
// debounced level only follows the input after 2^DB_CNT_W unchanged cycles.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CNT_W = DB_CNT_W_DEF
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic sync_level,
  output logic level
);

  logic                sync1_q;
  logic                sync2_q;
  logic                level_q;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == '1) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample pre-edge values and the synchronizer really is two stages.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_level = sync2_q;
  assign level      = level_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Four debounced push-buttons feeding a one-event-per-press color FSM with a
// valid/ack handshake. Define PRESS_COUNT_EN to add the press_count output.
module btn_input_ctrl
  import btn_pkg::*;
#(
  parameter int DB_CNT_W = DB_CNT_W_DEF
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       Btn_U,
  input  logic       Btn_R,
  input  logic       Btn_D,
  input  logic       Btn_L,
  input  logic       enable,
  input  logic       color_ack,
  output logic       color_valid,
  output logic [1:0] color_code,
  output logic [3:0] btn_level,
  output logic       multi_err
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  logic [3:0] btn_raw;
  logic [3:0] sync_level;
  logic [3:0] level;
  logic [3:0] level_prev_q;
  logic [3:0] rise;

  state_e     state_q, state_d;
  color_e     code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [1:0] settle_q, settle_d;
`ifdef PRESS_COUNT_EN
  logic [7:0] press_cnt_q, press_cnt_d;
`endif

  assign btn_raw = {Btn_U, Btn_R, Btn_D, Btn_L};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DB_CNT_W(DB_CNT_W)) u_db (
      .board_clk  (board_clk),
      .Reset      (Reset),
      .btn_raw    (btn_raw[i]),
      .sync_level (sync_level[i]),
      .level      (level[i])
    );
  end

  assign rise = level & ~level_prev_q;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
`ifdef PRESS_COUNT_EN
    press_cnt_d = press_cnt_q;
`endif
    case (state_q)
      // Debounced levels restart from 0 after reset, so also wait for the
      // synchronizers to settle low; a button held through reset is not a press.
      ST_WAIT_REL: begin
        if (level == 4'd0 && sync_level == 4'd0 && settle_q == 2'd3) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (enable) begin
          if (rise != 4'd0) begin
            if (is_onehot(rise) && (level & ~rise) == 4'd0) begin
              state_d = ST_HOLD;
              valid_d = 1'b1;
              code_d  = color_of(rise);
`ifdef PRESS_COUNT_EN
              press_cnt_d = press_cnt_q + 8'd1;
`endif
            end else begin
              state_d = ST_WAIT_REL;
              err_d   = 1'b1;
            end
          end
        end else if (level != 4'd0) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_HOLD: begin
        if (!enable || color_ack) begin
          state_d = ST_WAIT_REL;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_REL;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_WAIT_REL;
      code_q       <= COLOR_U;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      settle_q     <= 2'd0;
      level_prev_q <= 4'd0;
`ifdef PRESS_COUNT_EN
      press_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
      level_prev_q <= level;
`ifdef PRESS_COUNT_EN
      press_cnt_q  <= press_cnt_d;
`endif
    end
  end

  assign color_valid = valid_q;
  assign color_code  = code_q;
  assign btn_level   = level;
  assign multi_err   = err_q;
`ifdef PRESS_COUNT_EN
  assign press_count = press_cnt_q;
`endif

endmodule
